// File: rtl/nest3_index_decoder.sv
// rtl/nest3_index_decoder.sv - linear tile index to 3-D nested coordinates via two serial divisions
// Optional range check enabled by defining NEST3_DEC_RANGE_CHECK_EN.
module nest3_index_decoder #(
    parameter int CW     = 16,
    parameter int n0_max = 4,
    parameter int n1_max = 2,
    parameter int n2_max = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clean,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_idx,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1,
    output logic [CW-1:0] cnt2,
    output logic          out_err,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, DIV0, DIV1, DONE} state_t;

    localparam int          SW   = $clog2(CW + 1);
    localparam logic [SW-1:0] LAST = SW'(CW - 1);
    // A degenerate geometry (any zero extent) never accepts work.
    localparam bit GEOM_OK = (n0_max >= 1) && (n1_max >= 1) && (n2_max >= 1);

    state_t        state, state_next;
    logic [SW-1:0] step;
    logic [CW-1:0] rem;
    logic [CW-1:0] dvd;
    logic [CW-1:0] divisor;
    logic [CW:0]   shifted;
    logic [CW:0]   diff;
    logic          qbit;
    logic [CW-1:0] rem_next;
    logic [CW-1:0] q_next;
    logic          accept;
    logic          last_step;

    assign in_ready  = (state == IDLE) && GEOM_OK;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign last_step = (step == LAST);

    // One restoring step: dividend bits enter the remainder MSB first while
    // quotient bits shift into the vacated LSBs of the dividend register.
    assign divisor  = (state == DIV0) ? CW'(n0_max) : CW'(n1_max);
    assign shifted  = {rem, dvd[CW-1]};
    assign diff     = shifted - {1'b0, divisor};
    assign qbit     = ~diff[CW];
    assign rem_next = qbit ? diff[CW-1:0] : shifted[CW-1:0];
    assign q_next   = {dvd[CW-2:0], qbit};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (clean) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept)    state_next = DIV0;
                DIV0:    if (last_step) state_next = DIV1;
                DIV1:    if (last_step) state_next = DONE;
                DONE:    if (out_ready) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

`ifdef NEST3_DEC_RANGE_CHECK_EN
    localparam logic [3*CW-1:0] LIMIT = (3*CW)'(n0_max) * (3*CW)'(n1_max) * (3*CW)'(n2_max);
    logic [CW-1:0] idx_q;
    logic          err_q;

    assign out_err = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
            err_q <= 1'b0;
        end else if (!clean) begin
            if (state == IDLE && accept) begin
                idx_q <= in_idx;
                err_q <= 1'b0;
            end else if (state == DIV1 && last_step) begin
                err_q <= ({{(2*CW){1'b0}}, idx_q} >= LIMIT);
            end
        end
    end
`else
    assign out_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            step <= '0;
            rem  <= '0;
            dvd  <= '0;
            cnt0 <= '0;
            cnt1 <= '0;
            cnt2 <= '0;
        end else if (clean) begin
            step <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        dvd  <= in_idx;
                        rem  <= '0;
                        step <= '0;
                    end
                end
                DIV0, DIV1: begin
                    step <= last_step ? '0 : step + 1'b1;
                    dvd  <= q_next;
                    rem  <= last_step ? '0 : rem_next;
                    if (last_step && state == DIV0) begin
                        cnt0 <= rem_next;
                    end
                    if (last_step && state == DIV1) begin
                        cnt1 <= rem_next;
                        cnt2 <= q_next;
                    end
                end
                default: begin
                    step <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nest3_index_decoder.sv
// tb/tb_nest3_index_decoder.sv - directed self-checking bench for nest3_index_decoder
module tb_nest3_index_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        clean;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_idx;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] cnt0, cnt1, cnt2;
    logic        out_err;
    logic        busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

`ifdef NEST3_DEC_RANGE_CHECK_EN
    localparam logic ERR16 = 1'b1;
`else
    localparam logic ERR16 = 1'b0;
`endif

    nest3_index_decoder #(.CW(16), .n0_max(4), .n1_max(2), .n2_max(2)) dut (
        .clk(clk), .rst(rst), .clean(clean),
        .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx),
        .out_valid(out_valid), .out_ready(out_ready),
        .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2),
        .out_err(out_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepts idx, then counts edges until out_valid (lat = -1 on timeout).
    task automatic accept_and_wait(input logic [15:0] idx, output int lat, output bit rdy_hi);
        lat = -1;
        rdy_hi = 1'b0;
        in_idx = idx;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            tick();
            if (out_valid) begin
                lat = n;
                break;
            end
            if (in_ready) rdy_hi = 1'b1;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clean = 1'b0; in_valid = 1'b0; in_idx = '0; out_ready = 1'b0;
        tick(); tick();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else pass_cnt++;
        total_cnt++; if ({cnt0, cnt1, cnt2} !== 48'd0) $display("FAIL reset_cnts got %h exp 0", {cnt0, cnt1, cnt2}); else pass_cnt++;
        total_cnt++; if (out_err !== 1'b0) $display("FAIL reset_out_err got %b exp 0", out_err); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
        rst = 1'b0;
        tick();
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else pass_cnt++;
    endtask

    task automatic test_latency();
        int lat; bit rdy_hi;
        accept_and_wait(16'd13, lat, rdy_hi);
        total_cnt++; if (lat !== 32) $display("FAIL lat13_edges got %0d exp 32", lat); else pass_cnt++;
        total_cnt++; if ({cnt0, cnt1, cnt2} !== {16'd1, 16'd1, 16'd1}) $display("FAIL lat13_cnts got %0d/%0d/%0d exp 1/1/1", cnt0, cnt1, cnt2); else pass_cnt++;
        total_cnt++; if (out_err !== 1'b0) $display("FAIL lat13_err got %b exp 0", out_err); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL lat13_busy got %b exp 1", busy); else pass_cnt++;
        release_result();
        total_cnt++; if ({out_valid, busy, in_ready} !== 3'b001) $display("FAIL lat13_release got %b exp 001", {out_valid, busy, in_ready}); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int lat; bit rdy_hi;
        accept_and_wait(16'd0, lat, rdy_hi);
        total_cnt++; if ({cnt0, cnt1, cnt2} !== 48'd0) $display("FAIL b2b0_cnts got %0d/%0d/%0d exp 0/0/0", cnt0, cnt1, cnt2); else pass_cnt++;
        total_cnt++; if (rdy_hi !== 1'b0) $display("FAIL b2b0_in_ready got %b exp 0", rdy_hi); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL b2b0_ready_done got %b exp 0", in_ready); else pass_cnt++;
        release_result();
        accept_and_wait(16'd15, lat, rdy_hi);
        total_cnt++; if (lat !== 32) $display("FAIL b2b15_edges got %0d exp 32", lat); else pass_cnt++;
        total_cnt++; if ({cnt0, cnt1, cnt2} !== {16'd3, 16'd1, 16'd1}) $display("FAIL b2b15_cnts got %0d/%0d/%0d exp 3/1/1", cnt0, cnt1, cnt2); else pass_cnt++;
        total_cnt++; if (rdy_hi !== 1'b0) $display("FAIL b2b15_in_ready got %b exp 0", rdy_hi); else pass_cnt++;
        total_cnt++; if (out_err !== 1'b0) $display("FAIL b2b15_err got %b exp 0", out_err); else pass_cnt++;
        release_result();
    endtask

    task automatic test_range();
        int lat; bit rdy_hi;
        accept_and_wait(16'd16, lat, rdy_hi);
        total_cnt++; if ({cnt0, cnt1, cnt2} !== {16'd0, 16'd0, 16'd2}) $display("FAIL range16_cnts got %0d/%0d/%0d exp 0/0/2", cnt0, cnt1, cnt2); else pass_cnt++;
        total_cnt++; if (out_err !== ERR16) $display("FAIL range16_err got %b exp %b", out_err, ERR16); else pass_cnt++;
        release_result();
        accept_and_wait(16'hFFFF, lat, rdy_hi);
        total_cnt++; if ({cnt0, cnt1, cnt2} !== {16'd3, 16'd1, 16'd8191}) $display("FAIL rangeffff_cnts got %0d/%0d/%0d exp 3/1/8191", cnt0, cnt1, cnt2); else pass_cnt++;
        total_cnt++; if (out_err !== ERR16) $display("FAIL rangeffff_err got %b exp %b", out_err, ERR16); else pass_cnt++;
        release_result();
    endtask

    task automatic test_stall();
        int lat; bit rdy_hi;
        accept_and_wait(16'd7, lat, rdy_hi);
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if ({out_valid, cnt0, cnt1, cnt2, out_err, in_ready} !== {1'b1, 16'd3, 16'd1, 16'd0, 1'b0, 1'b0})
                $display("FAIL stall_cycle%0d got v=%b %0d/%0d/%0d e=%b r=%b exp v=1 3/1/0 e=0 r=0", i, out_valid, cnt0, cnt1, cnt2, out_err, in_ready);
            else pass_cnt++;
            tick();
        end
        release_result();
        total_cnt++; if ({out_valid, in_ready, busy} !== 3'b010) $display("FAIL stall_release got %b exp 010", {out_valid, in_ready, busy}); else pass_cnt++;
    endtask

    task automatic test_clean();
        int lat; bit rdy_hi; bit seen_valid;
        seen_valid = 1'b0;
        in_idx = 16'd5;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        clean = 1'b1;
        out_ready = 1'b1;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL clean_pre_ready got %b exp 0", in_ready); else pass_cnt++;
        tick();
        clean = 1'b0;
        out_ready = 1'b0;
        total_cnt++; if ({in_ready, busy, out_valid} !== 3'b100) $display("FAIL clean_idle got %b exp 100", {in_ready, busy, out_valid}); else pass_cnt++;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) seen_valid = 1'b1;
        end
        total_cnt++; if (seen_valid !== 1'b0) $display("FAIL clean_no_valid got %b exp 0", seen_valid); else pass_cnt++;
        accept_and_wait(16'd9, lat, rdy_hi);
        total_cnt++; if (lat !== 32) $display("FAIL clean_next_edges got %0d exp 32", lat); else pass_cnt++;
        total_cnt++; if ({cnt0, cnt1, cnt2} !== {16'd1, 16'd0, 16'd1}) $display("FAIL clean_next_cnts got %0d/%0d/%0d exp 1/0/1", cnt0, cnt1, cnt2); else pass_cnt++;
        release_result();
    endtask

    task automatic test_reset_mid();
        bit seen_valid;
        seen_valid = 1'b0;
        in_idx = 16'd6;
        in_valid = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        total_cnt++; if ({out_valid, busy, out_err} !== 3'b000) $display("FAIL rstmid_flags got %b exp 000", {out_valid, busy, out_err}); else pass_cnt++;
        total_cnt++; if ({cnt0, cnt1, cnt2} !== 48'd0) $display("FAIL rstmid_cnts got %0d/%0d/%0d exp 0/0/0", cnt0, cnt1, cnt2); else pass_cnt++;
        rst = 1'b0;
        in_valid = 1'b0;
        tick();
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready got %b exp 1", in_ready); else pass_cnt++;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) seen_valid = 1'b1;
        end
        total_cnt++; if (seen_valid !== 1'b0) $display("FAIL rstmid_no_stale got %b exp 0", seen_valid); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_range();
        test_stall();
        test_clean();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
